// File: rtl/c17_bist_pkg.sv
// Shared types, default constants and the Galois shift step for the c17 BIST wrapper.
package c17_bist_pkg;

  typedef enum logic [2:0] {IDLE, SEED, RUN, FLUSH, DONE} state_t;

  localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;
  localparam logic [15:0] DEF_LFSR_SEED = 16'h0001;
  localparam logic [15:0] DEF_MISR_POLY = 16'hB400;

  // Widest register the step function handles; callers zero-extend into it.
  localparam int unsigned GALOIS_MAX_W = 64;

  // One right-shifting Galois step: feedback mask applied when the bit shifted out is 1.
  function automatic logic [GALOIS_MAX_W-1:0] galois_next(
    input logic [GALOIS_MAX_W-1:0] cur,
    input logic [GALOIS_MAX_W-1:0] poly
  );
    return (cur >> 1) ^ (cur[0] ? poly : '0);
  endfunction

endpackage

// File: rtl/c17_bist_ctrl_core.sv
// ISCAS-85 c17: six two-input NAND gates, purely combinational.
module c17_core (
  input  logic gat1,
  input  logic gat2,
  input  logic gat3,
  input  logic gat6,
  input  logic gat7,
  output logic gat22,
  output logic gat23
);

  logic n10, n11, n16, n19;

  assign n10   = ~(gat1 & gat3);
  assign n11   = ~(gat3 & gat6);
  assign n16   = ~(gat2 & n11);
  assign n19   = ~(n11 & gat7);
  assign gat22 = ~(n10 & n16);
  assign gat23 = ~(n16 & n19);

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST wrapper: LFSR pattern source, NUM_CH shared c17 cores, MISR compactor and session FSM.
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int unsigned          NUM_CH      = 1,
  parameter int unsigned          LFSR_W      = 16,
  parameter logic [LFSR_W-1:0]    LFSR_POLY   = LFSR_W'(DEF_LFSR_POLY),
  parameter logic [LFSR_W-1:0]    LFSR_SEED   = LFSR_W'(DEF_LFSR_SEED),
  parameter int unsigned          MISR_W      = 16,
  parameter logic [MISR_W-1:0]    MISR_POLY   = MISR_W'(DEF_MISR_POLY),
  parameter int unsigned          PATTERN_CNT = 255,
  parameter int unsigned          PIPE        = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MISR_W-1:0]       golden_sig,
  input  logic [5*NUM_CH-1:0]     func_in,
  output logic [2*NUM_CH-1:0]     func_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [MISR_W-1:0]       signature
);

  localparam int unsigned IN_W  = 5 * NUM_CH;
  localparam int unsigned OUT_W = 2 * NUM_CH;
  localparam int unsigned CNT_W = $clog2(PATTERN_CNT + 1);

  // Parameter sanity checks at elaboration.
  if (NUM_CH < 1) begin : g_err_ch
    $error("NUM_CH must be >= 1");
  end
  if (MISR_W < OUT_W) begin : g_err_misr
    $error("MISR_W must be >= 2*NUM_CH");
  end
  if (LFSR_W < 5 || LFSR_W > GALOIS_MAX_W || MISR_W > GALOIS_MAX_W) begin : g_err_w
    $error("LFSR_W/MISR_W out of range");
  end
  if (LFSR_SEED == '0) begin : g_err_seed
    $error("LFSR_SEED must be nonzero");
  end
  if (PATTERN_CNT < 1 || PIPE > 1) begin : g_err_cnt
    $error("PATTERN_CNT must be >= 1 and PIPE 0 or 1");
  end

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [MISR_W-1:0] misr_q, misr_d, misr_step;
  logic [MISR_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  pipe_q, pipe_d;
  logic              pass_q, pass_d;
  logic [IN_W-1:0]   lfsr_pat, core_in;
  logic [OUT_W-1:0]  core_out, resp;
  logic              busy_int, last_pat;

  // Channel k input bit i taps lfsr[(5k+i) mod LFSR_W].
  for (genvar b = 0; b < IN_W; b++) begin : g_tap
    assign lfsr_pat[b] = lfsr_q[b % LFSR_W];
  end

  assign busy_int = (state_q != IDLE);
  assign core_in  = busy_int ? lfsr_pat : func_in;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_core
    c17_core u_core (
      .gat1  (core_in[5*k]),
      .gat2  (core_in[5*k+1]),
      .gat3  (core_in[5*k+2]),
      .gat6  (core_in[5*k+3]),
      .gat7  (core_in[5*k+4]),
      .gat22 (core_out[2*k]),
      .gat23 (core_out[2*k+1])
    );
  end

  assign resp      = (PIPE != 0) ? pipe_q : core_out;
  assign lfsr_step = LFSR_W'(galois_next(GALOIS_MAX_W'(lfsr_q), GALOIS_MAX_W'(LFSR_POLY)));
  assign misr_step = MISR_W'(galois_next(GALOIS_MAX_W'(misr_q), GALOIS_MAX_W'(MISR_POLY)))
                   ^ MISR_W'(resp);
  assign last_pat  = (cnt_q == CNT_W'(PATTERN_CNT - 1));

  // Next-state logic for the session FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    pipe_d  = pipe_q;
    pass_d  = pass_q;
    sig_d   = sig_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = SEED;
      end
      SEED: begin
        lfsr_d  = LFSR_SEED;
        misr_d  = '0;
        cnt_d   = '0;
        pipe_d  = '0;
        pass_d  = 1'b0;
        sig_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        lfsr_d = lfsr_step;
        cnt_d  = cnt_q + CNT_W'(1);
        pipe_d = core_out;
        // With the pipe stage the first RUN cycle has no valid response yet.
        if (PIPE == 0 || cnt_q != '0) misr_d = misr_step;
        if (last_pat) state_d = (PIPE != 0) ? FLUSH : DONE;
      end
      FLUSH: begin
        misr_d  = misr_step;
        state_d = DONE;
      end
      DONE: begin
        sig_d   = misr_q;
        pass_d  = (misr_q == golden_sig);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; async reset aborts any session.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      pipe_q  <= '0;
      pass_q  <= 1'b0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      pipe_q  <= pipe_d;
      pass_q  <= pass_d;
      sig_q   <= sig_d;
    end
  end

  assign busy      = busy_int;
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign signature = sig_q;
  assign func_out  = busy_int ? '0 : core_out;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Self-checking bench: three wrapper configurations against a behavioural c17/BIST model.
module tb_c17_bist_ctrl;
  import c17_bist_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // A: NUM_CH=1, PC=4, PIPE=0.  B: same with PIPE=1.  W: NUM_CH=2, PC=9, PIPE=1.
  logic        start_a = 1'b0, start_b = 1'b0, start_w = 1'b0;
  logic [15:0] gold_a = '0, gold_b = '0, gold_w = '0;
  logic [4:0]  fin_a = '0, fin_b = '0;
  logic [9:0]  fin_w = '0;
  logic [1:0]  fout_a, fout_b;
  logic [3:0]  fout_w;
  logic        busy_a, busy_b, busy_w, done_a, done_b, done_w, pass_a, pass_b, pass_w;
  logic [15:0] sig_a, sig_b, sig_w;

  c17_bist_ctrl #(.NUM_CH(1), .PATTERN_CNT(4), .PIPE(0)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .golden_sig(gold_a), .func_in(fin_a),
    .func_out(fout_a), .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a));

  c17_bist_ctrl #(.NUM_CH(1), .PATTERN_CNT(4), .PIPE(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .golden_sig(gold_b), .func_in(fin_b),
    .func_out(fout_b), .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b));

  c17_bist_ctrl #(.NUM_CH(2), .PATTERN_CNT(9), .PIPE(1)) u_dut_w (
    .clk(clk), .rst(rst), .start(start_w), .golden_sig(gold_w), .func_in(fin_w),
    .func_out(fout_w), .busy(busy_w), .done(done_w), .pass(pass_w), .signature(sig_w));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // c17 as sum-of-products; v = {gat7,gat6,gat3,gat2,gat1}, result = {gat23,gat22}.
  function automatic logic [1:0] c17_ref(input logic [4:0] v);
    logic g1, g2, g3, g6, g7, blk;
    g1 = v[0]; g2 = v[1]; g3 = v[2]; g6 = v[3]; g7 = v[4];
    blk = g3 & g6;
    return {(g2 | g7) & ~blk, (g1 & g3) | (g2 & ~blk)};
  endfunction

  // Signature over pc patterns: pattern p is the seed advanced p times.
  function automatic logic [15:0] sig_ref(input int nch, input int pc);
    logic [63:0] l, m, resp;
    logic [4:0]  pat;
    l = 64'h0001;
    m = '0;
    for (int p = 0; p < pc; p++) begin
      resp = '0;
      for (int k = 0; k < nch; k++) begin
        for (int i = 0; i < 5; i++) pat[i] = l[(5 * k + i) % 16];
        resp = resp | (64'(c17_ref(pat)) << (2 * k));
      end
      m = (galois_next(m, 64'hB400) ^ resp) & 64'hFFFF;
      l = galois_next(l, 64'hB400) & 64'hFFFF;
    end
    return m[15:0];
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0: return done_a;
      1: return done_b;
      default: return done_w;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0: return busy_a;
      1: return busy_b;
      default: return busy_w;
    endcase
  endfunction

  function automatic logic get_pass(input int sel);
    case (sel)
      0: return pass_a;
      1: return pass_b;
      default: return pass_w;
    endcase
  endfunction

  function automatic logic [15:0] get_sig(input int sel);
    case (sel)
      0: return sig_a;
      1: return sig_b;
      default: return sig_w;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0: start_a = v;
      1: start_b = v;
      default: start_w = v;
    endcase
  endtask

  task automatic set_gold(input int sel, input logic [15:0] v);
    case (sel)
      0: gold_a = v;
      1: gold_b = v;
      default: gold_w = v;
    endcase
  endtask

  // One session: start sampled at edge N; done expected only in cycle N+lat.
  task automatic run_session(input string tag, input int sel, input int lat,
                             input logic [15:0] gold, input logic exp_pass,
                             input logic [15:0] exp_sig, input bit poke_run);
    int first = -1;
    int ndone = 0;
    set_gold(sel, gold);
    @(posedge clk); #1 set_start(sel, 1'b1);
    @(posedge clk); #1 set_start(sel, 1'b0);
    for (int m = 1; m <= lat + 3; m++) begin
      @(negedge clk);
      if (m == 1) check({tag, " busy@N+1"}, get_busy(sel), 1'b1);
      if (m == 2 && sel == 0) check({tag, " fout gated"}, fout_a, 2'b00);
      if (get_done(sel)) begin
        ndone++;
        if (first < 0) first = m;
      end
      if (poke_run && m == 3) set_start(sel, 1'b1);
      @(posedge clk); #1;
      if (poke_run && m == 3) set_start(sel, 1'b0);
    end
    check({tag, " done cycle"}, 64'(first), 64'(lat));
    check({tag, " done count"}, 64'(ndone), 64'd1);
    check({tag, " busy after"}, get_busy(sel), 1'b0);
    check({tag, " signature"}, get_sig(sel), exp_sig);
    check({tag, " pass"}, get_pass(sel), exp_pass);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s1, s2, flip;
    logic [4:0]  v5;
    int          last_done, ndone, spacing_bad, idle_ok, ndone_rst;

    s1 = sig_ref(1, 4);
    s2 = sig_ref(2, 9);

    repeat (2) @(posedge clk);
    // Reset values while rst is still asserted.
    @(negedge clk);
    check("rst busy", busy_a, 1'b0);
    check("rst done", done_b, 1'b0);
    check("rst pass", pass_w, 1'b0);
    check("rst sig", sig_a, 16'h0);
    rst = 1'b0;

    // Functional mode.
    fin_a = 5'b00000; #1 check("func 00000", fout_a, 2'b00);
    fin_a = 5'b11111; #1 check("func 11111", fout_a, 2'b01);
    for (int i = 0; i < 20; i++) begin
      v5 = 5'($urandom_range(0, 31));
      fin_b = v5; #1 check("func rand", fout_b, c17_ref(v5));
    end
    for (int i = 0; i < 1024; i++) begin
      fin_w = 10'(i);
      #1 check("func exh2", fout_w, {c17_ref(fin_w[9:5]), c17_ref(fin_w[4:0])});
    end

    // Sessions: matching and corrupted golden, PIPE 0 and 1.
    fin_a = 5'b11111;
    run_session("A good", 0, 6, s1, 1'b1, s1, 1'b0);
    run_session("A bad", 0, 6, s1 ^ 16'h1, 1'b0, s1, 1'b0);
    run_session("B good", 1, 7, s1, 1'b1, s1, 1'b0);
    run_session("A poke", 0, 6, s1, 1'b1, s1, 1'b1);

    // Randomized sessions on the two-channel instance.
    for (int r = 0; r < 4; r++) begin
      flip = 16'($urandom_range(1, 65535));
      if ($urandom_range(0, 1) == 1)
        run_session("W good", 2, 12, s2, 1'b1, s2, ($urandom_range(0, 1) == 1));
      else
        run_session("W bad", 2, 12, s2 ^ flip, 1'b0, s2, ($urandom_range(0, 1) == 1));
    end

    // Start held high: back-to-back sessions, done every PC+PIPE+3 = 7 cycles.
    gold_a = s1;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1;
    last_done = -1; ndone = 0; spacing_bad = 0;
    for (int m = 1; m <= 27; m++) begin
      @(negedge clk);
      if (done_a) begin
        if (last_done < 0) check("b2b first done", 64'(m), 64'd6);
        else if (m - last_done != 7) spacing_bad++;
        last_done = m;
        ndone++;
      end
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    check("b2b done count", 64'(ndone), 64'd4);
    check("b2b spacing", 64'(spacing_bad), 64'd0);
    idle_ok = 0;
    for (int m = 0; m < 20 && idle_ok == 0; m++) begin
      @(negedge clk);
      if (!busy_a) idle_ok = 1;
    end
    check("b2b back to idle", 64'(idle_ok), 64'd1);
    check("b2b pass", pass_a, 1'b1);

    // Reset in cycle N+3 (RUN) aborts the session with no done.
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst mid busy", busy_a, 1'b0);
    @(negedge clk);
    check("rst mid pass", pass_a, 1'b0);
    check("rst mid sig", sig_a, 16'h0);
    rst = 1'b0;
    ndone_rst = 0;
    for (int m = 0; m < 10; m++) begin
      @(negedge clk);
      if (done_a) ndone_rst++;
    end
    check("rst mid no done", 64'(ndone_rst), 64'd0);
    run_session("A after rst", 0, 6, s1, 1'b1, s1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
